// File: rtl/vera_pkg.sv
// Shared constants and types for the VERA host-bus / VRAM block.
// Optional feature macro: VERA_DECREMENT_EN (see vera_top).
package vera_pkg;

    localparam logic [2:0] REG_ADDR_L = 3'd0;
    localparam logic [2:0] REG_ADDR_M = 3'd1;
    localparam logic [2:0] REG_ADDR_H = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;

    // ADDR_H field positions
    localparam int STEP_MSB = 3;
    localparam int STEP_LSB = 0;
    localparam int DECR_BIT = 4;

    localparam logic [7:0] ADDR_H_RST = 8'h00;
    localparam logic [7:0] DATA_RST   = 8'h00;

    typedef struct packed {
        logic       cs_n;
        logic       rw_n;
        logic [2:0] a;
        logic [7:0] d;
    } bus_req_t;

    localparam bus_req_t BUS_RST = '0;

endpackage

// File: rtl/vera_extbus_sync.sv
// Brings the asynchronous host bus into clk25: phy2 synchroniser, pin registers,
// bus latches and a one-cycle commit strobe at the end of each selected bus cycle.
module vera_extbus_sync
    import vera_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phy2_i,
    input  logic       cs_n_i,
    input  logic       rw_n_i,
    input  logic [2:0] a_i,
    input  logic [7:0] d_i,
    output bus_req_t   bus_o,
    output logic       commit_o
);

    logic     s1_q, s1_d;
    logic     s2_q, s2_d;
    bus_req_t pin_q, pin_d;
    bus_req_t latch_q, latch_d;

    always_comb begin
        s1_d    = phy2_i;
        s2_d    = s1_q;
        pin_d   = '{cs_n: cs_n_i, rw_n: rw_n_i, a: a_i, d: d_i};
        // latches follow the pins only while phy2 is high, so they hold the
        // last in-cycle values when the falling edge is detected
        latch_d = s1_q ? pin_q : latch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            pin_q   <= BUS_RST;
            latch_q <= BUS_RST;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            pin_q   <= pin_d;
            latch_q <= latch_d;
        end
    end

    assign bus_o    = latch_q;
    assign commit_o = s2_q && !s1_q && !latch_q.cs_n;

endmodule

// File: rtl/vera_top.sv
// VERA top: host register file (ADDR_L/M/H, DATA) over an auto-stepping VRAM port.
// Define VERA_DECREMENT_EN to make ADDR_H[4] select a decrementing DATA step.
module vera_top
    import vera_pkg::*;
#(
    parameter int VRAM_AW = 16
) (
    input  logic       clk25,
    input  logic       extbus_res_n,
    input  logic       extbus_phy2,
    input  logic       extbus_cs_n,
    input  logic       extbus_rw_n,
    input  logic [2:0] extbus_a,
    inout  wire  [7:0] extbus_d
);

    bus_req_t           bus;
    logic               commit;
    logic [VRAM_AW-1:0] addr_q, addr_d, addr_next, step;
    logic [15:0]        addr16;
    logic [7:0]         addr_h_q, addr_h_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         ram_q, rd_mux;
    logic [1:0]         pf_pipe_q, pf_pipe_d;
    logic               pf_start, ram_we, decr;

    vera_extbus_sync u_sync (
        .clk      (clk25),
        .rst_n    (extbus_res_n),
        .phy2_i   (extbus_phy2),
        .cs_n_i   (extbus_cs_n),
        .rw_n_i   (extbus_rw_n),
        .a_i      (extbus_a),
        .d_i      (extbus_d),
        .bus_o    (bus),
        .commit_o (commit)
    );

    assign addr16 = 16'(addr_q);
    assign step   = VRAM_AW'(addr_h_q[STEP_MSB:STEP_LSB]);
`ifdef VERA_DECREMENT_EN
    assign decr   = addr_h_q[DECR_BIT];
`else
    assign decr   = 1'b0;
`endif
    assign addr_next = decr ? addr_q - step : addr_q + step;

    always_comb begin
        addr_d   = addr_q;
        addr_h_d = addr_h_q;
        data_d   = data_q;
        pf_start = 1'b0;
        ram_we   = 1'b0;
        // prefetched byte lands two cycles after the address settles
        if (pf_pipe_q[1]) data_d = ram_q;
        if (commit) begin
            if (!bus.rw_n) begin
                case (bus.a)
                    REG_ADDR_L: begin
                        addr_d   = VRAM_AW'({addr16[15:8], bus.d});
                        pf_start = 1'b1;
                    end
                    REG_ADDR_M: begin
                        addr_d   = VRAM_AW'({bus.d, addr16[7:0]});
                        pf_start = 1'b1;
                    end
                    REG_ADDR_H: addr_h_d = bus.d;
                    REG_DATA: begin
                        ram_we   = 1'b1;
                        data_d   = bus.d;
                        addr_d   = addr_next;
                        pf_start = 1'b1;
                    end
                    default: ;
                endcase
            end else if (bus.a == REG_DATA) begin
                addr_d   = addr_next;
                pf_start = 1'b1;
            end
        end
        pf_pipe_d = {pf_pipe_q[0], pf_start};
    end

    always_ff @(posedge clk25 or negedge extbus_res_n) begin
        if (!extbus_res_n) begin
            addr_q    <= '0;
            addr_h_q  <= ADDR_H_RST;
            data_q    <= DATA_RST;
            pf_pipe_q <= '0;
        end else begin
            addr_q    <= addr_d;
            addr_h_q  <= addr_h_d;
            data_q    <= data_d;
            pf_pipe_q <= pf_pipe_d;
        end
    end

    // single-port VRAM, read-first; contents survive reset
    logic [7:0] vram [2**VRAM_AW];

    always_ff @(posedge clk25) begin
        if (ram_we) vram[addr_q] <= bus.d;
        ram_q <= vram[addr_q];
    end

    always_comb begin
        rd_mux = 8'h00;
        case (extbus_a)
            REG_ADDR_L: rd_mux = addr16[7:0];
            REG_ADDR_M: rd_mux = addr16[15:8];
            REG_ADDR_H: rd_mux = addr_h_q;
            REG_DATA:   rd_mux = data_q;
            default:    rd_mux = 8'h00;
        endcase
    end

    assign extbus_d = (extbus_res_n && !extbus_cs_n && extbus_rw_n && extbus_phy2)
                      ? rd_mux : 8'hzz;

endmodule

// File: tb/tb_vera_top.sv
// Directed + random host-bus bench for vera_top with a register/VRAM reference model.
module tb_vera_top;

    logic       clk25  = 1'b0;
    logic       res_n  = 1'b0;
    logic       phy2   = 1'b0;
    logic       cs_n   = 1'b1;
    logic       rw_n   = 1'b1;
    logic [2:0] a      = 3'd0;
    logic [7:0] drv_d  = 8'h00;
    logic       drv_en = 1'b0;
    tri1  [7:0] d_bus;

    assign d_bus = drv_en ? drv_d : 8'hzz;

    vera_top #(.VRAM_AW(16)) dut (
        .clk25        (clk25),
        .extbus_res_n (res_n),
        .extbus_phy2  (phy2),
        .extbus_cs_n  (cs_n),
        .extbus_rw_n  (rw_n),
        .extbus_a     (a),
        .extbus_d     (d_bus)
    );

    always #20 clk25 = ~clk25;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int         m_addr  = 0;
    logic [7:0] m_addrh = 8'h00;
    logic [7:0] m_mem [int];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int ad);
        int s;
        s = int'(m_addrh[3:0]);
`ifdef VERA_DECREMENT_EN
        if (m_addrh[4]) return (ad - s) & 'hFFFF;
`endif
        return (ad + s) & 'hFFFF;
    endfunction

    task automatic bus_cycle(input logic rw, input logic [2:0] ra, input logic [7:0] wd,
                             output logic [7:0] rd);
        phy2 = 1'b0;
        #100;
        cs_n = 1'b0; rw_n = rw; a = ra; drv_d = wd; drv_en = !rw;
        #150;
        phy2 = 1'b1;
        #240;
        rd = d_bus;
        #10;
        phy2 = 1'b0;
        #40;
        cs_n = 1'b1; rw_n = 1'b1; drv_en = 1'b0;
        #200;
    endtask

    // one host access; reads are checked against the model's pre-access state
    task automatic acc(input string tag, input logic rw, input logic [2:0] ra, input logic [7:0] wd);
        logic [7:0] rd, exp;
        bit known;
        known = 1;
        case (ra)
            3'd0: exp = 8'(m_addr);
            3'd1: exp = 8'(m_addr >> 8);
            3'd2: exp = m_addrh;
            3'd3: begin
                known = m_mem.exists(m_addr);
                exp   = known ? m_mem[m_addr] : 8'h00;
            end
            default: exp = 8'h00;
        endcase
        bus_cycle(rw, ra, wd, rd);
        if (rw && known) check(tag, rd, exp);
        if (!rw) begin
            case (ra)
                3'd0: m_addr = (m_addr & 'hFF00) | int'(wd);
                3'd1: m_addr = (m_addr & 'h00FF) | (int'(wd) << 8);
                3'd2: m_addrh = wd;
                3'd3: begin m_mem[m_addr] = wd; m_addr = nxt(m_addr); end
                default: ;
            endcase
        end else if (ra == 3'd3) begin
            m_addr = nxt(m_addr);
        end
    endtask

    task automatic set_addr(input int ad);
        acc("set_l", 1'b0, 3'd0, 8'(ad));
        acc("set_m", 1'b0, 3'd1, 8'(ad >> 8));
    endtask

    initial begin
        // bus must float while held in reset, even with a read pending
        #40;
        cs_n = 1'b0; rw_n = 1'b1; a = 3'd0; phy2 = 1'b1;
        #20;
        check("z_in_reset", d_bus, 8'hFF);
        phy2 = 1'b0; cs_n = 1'b1;
        #63;
        res_n = 1'b1;
        #200;

        acc("rst_addr_l", 1'b1, 3'd0, 8'h00);
        acc("rst_addr_m", 1'b1, 3'd1, 8'h00);
        acc("rst_addr_h", 1'b1, 3'd2, 8'h00);

        // not selected: no drive
        a = 3'd4; rw_n = 1'b1; cs_n = 1'b1; phy2 = 1'b1;
        #200;
        check("z_cs_high", d_bus, 8'hFF);
        // selected write phase with host not driving: DUT must not drive
        cs_n = 1'b0; rw_n = 1'b0;
        #200;
        check("z_write", d_bus, 8'hFF);
        phy2 = 1'b0;
        #40;
        cs_n = 1'b1; rw_n = 1'b1;
        #300;

        // sequential writes, step 1
        set_addr(0);
        acc("w_addr_h", 1'b0, 3'd2, 8'h01);
        acc("w_d0", 1'b0, 3'd3, 8'h11);
        acc("w_d1", 1'b0, 3'd3, 8'h22);
        acc("w_d2", 1'b0, 3'd3, 8'h33);
        acc("seq_addr_l", 1'b1, 3'd0, 8'h00);
        acc("seq_addr_m", 1'b1, 3'd1, 8'h00);
        check("seq_model_l", 8'(m_addr), 8'h03);

        // read back
        set_addr(0);
        acc("r_d0", 1'b1, 3'd3, 8'h00);
        acc("r_d1", 1'b1, 3'd3, 8'h00);
        acc("r_d2", 1'b1, 3'd3, 8'h00);
        acc("rb_addr_l", 1'b1, 3'd0, 8'h00);

        // step values via ADDR_H, including the DECR bit
        acc("h_a5", 1'b0, 3'd2, 8'hA5);
        acc("h_a5_rd", 1'b1, 3'd2, 8'h00);
        acc("d_a5", 1'b1, 3'd3, 8'h00);
        acc("l_a5", 1'b1, 3'd0, 8'h00);
        acc("h_5a", 1'b0, 3'd2, 8'h5A);
        acc("h_5a_rd", 1'b1, 3'd2, 8'h00);
        acc("d_5a", 1'b1, 3'd3, 8'h00);
        acc("l_5a", 1'b1, 3'd0, 8'h00);
        acc("m_5a", 1'b1, 3'd1, 8'h00);
        acc("h_42", 1'b0, 3'd2, 8'h42);
        acc("h_42_rd", 1'b1, 3'd2, 8'h00);
        acc("d_42", 1'b1, 3'd3, 8'h00);
        acc("l_42", 1'b1, 3'd0, 8'h00);
        acc("m_42", 1'b1, 3'd1, 8'h00);

        // wrap at top of VRAM
        set_addr('hFFFF);
        acc("wrap_h", 1'b0, 3'd2, 8'h01);
        acc("wrap_w", 1'b0, 3'd3, 8'h77);
        acc("wrap_l", 1'b1, 3'd0, 8'h00);
        acc("wrap_m", 1'b1, 3'd1, 8'h00);
        set_addr('hFFFF);
        acc("wrap_rd", 1'b1, 3'd3, 8'h00);

        // decrement select
        set_addr(5);
        acc("dec_h", 1'b0, 3'd2, 8'h11);
        acc("dec_d", 1'b1, 3'd3, 8'h00);
`ifdef VERA_DECREMENT_EN
        check("dec_model", 8'(m_addr), 8'h04);
`else
        check("dec_model", 8'(m_addr), 8'h06);
`endif
        acc("dec_l", 1'b1, 3'd0, 8'h00);
        acc("dec_m", 1'b1, 3'd1, 8'h00);

        // step 0 write then read at the same address
        set_addr('h0040);
        acc("s0_h", 1'b0, 3'd2, 8'h00);
        acc("s0_w", 1'b0, 3'd3, 8'h5C);
        acc("s0_r", 1'b1, 3'd3, 8'h00);
        acc("s0_l", 1'b1, 3'd0, 8'h00);

        // reset in the middle of a DATA write: no VRAM update, registers cleared
        phy2 = 1'b0;
        #100;
        cs_n = 1'b0; rw_n = 1'b0; a = 3'd3; drv_d = 8'hC5; drv_en = 1'b1;
        #150;
        phy2 = 1'b1;
        #100;
        res_n = 1'b0;
        #100;
        phy2 = 1'b0;
        #40;
        cs_n = 1'b1; rw_n = 1'b1; drv_en = 1'b0;
        #100;
        res_n = 1'b1;
        #200;
        m_addr  = 0;
        m_addrh = 8'h00;
        acc("mr_addr_l", 1'b1, 3'd0, 8'h00);
        acc("mr_addr_m", 1'b1, 3'd1, 8'h00);
        acc("mr_addr_h", 1'b1, 3'd2, 8'h00);
        set_addr('h0040);
        acc("mr_vram", 1'b1, 3'd3, 8'h00);

        // random traffic; high address byte kept small so reads mostly hit known bytes
        for (int i = 0; i < 160; i++) begin
            logic       rw;
            logic [2:0] ra;
            logic [7:0] wd;
            rw = 1'($urandom_range(0, 1));
            ra = 3'($urandom_range(0, 7));
            wd = 8'($urandom);
            if (ra == 3'd1) wd = 8'($urandom_range(0, 1));
            acc("rand", rw, ra, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
